// File: rtl/dnot_pkg.sv
// Shared definitions for the single-bit gate checkers: FSM states, synchronizer depth
// and the reference inverter function.
package dnot_pkg;

  localparam int unsigned SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  // Reference response of an inverting gate under test.
  function automatic logic expected(input logic stim);
    return ~stim;
  endfunction

endpackage

// File: rtl/dnot_checker_if.sv
// Board-side bundle between the checker, its controller and the example under test.
interface dnot_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             stim;
  logic             obs_not;
  logic             obs_dnot;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    input  start, obs_not, obs_dnot,
    output stim, busy, done, pass, err_cnt
  );

  modport slave (
    output start, obs_not, obs_dnot,
    input  stim, busy, done, pass, err_cnt
  );
endinterface

// File: rtl/dnot_sync2.sv
// Multi-bit flop-chain synchronizer for the asynchronous example outputs.
module dnot_sync2
  import dnot_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/dnot_checker.sv
// Stimulus/response checker for the double-inverter example: drives an alternating
// stimulus, samples both synchronized outputs and counts inversion mismatches.
module dnot_checker
  import dnot_pkg::*;
#(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dnot_checker_if.master bus
);

  localparam int unsigned RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SUM_W = ERR_W + 1;

  state_t           state;
  logic [RND_W-1:0] round;
  logic [CNT_W-1:0] wait_cnt;
  logic             stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;

  logic [1:0]       obs_sync;
  logic             exp_bit;
  logic [1:0]       mism;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_next;
  logic             last_round;

  dnot_sync2 #(
    .WIDTH(2)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({bus.obs_not, bus.obs_dnot}),
    .q    (obs_sync)
  );

  // Mismatch count for this sample, added to the error counter with saturation.
  always_comb begin
    exp_bit    = expected(stim);
    mism       = 2'(obs_sync[1] != exp_bit) + 2'(obs_sync[0] != exp_bit);
    err_sum    = {1'b0, err_cnt} + SUM_W'(mism);
    err_next   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    last_round = (round == RND_W'(ROUNDS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      round    <= '0;
      wait_cnt <= '0;
      stim     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= DRIVE;
            busy    <= 1'b1;
            err_cnt <= '0;
            pass    <= 1'b0;
            round   <= '0;
          end
        end
        DRIVE: begin
          stim     <= round[0];
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(SETTLE - 1)) begin
            state <= SAMPLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          err_cnt <= err_next;
          if (last_round) begin
            // Verdict is taken from the count including this final sample.
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            stim  <= 1'b0;
          end else begin
            round <= round + RND_W'(1);
            state <= DRIVE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stim    = stim;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.pass    = pass;
  assign bus.err_cnt = err_cnt;

endmodule

// File: tb/tb_dnot_checker.sv
// Directed bench for dnot_checker: behavioural example models on the board side and a
// per-run scoreboard of expected error counts and verdicts.
module tb_dnot_checker;

  localparam int ROUNDS = 16;
  localparam int SETTLE = 2;
  localparam int RUN_LEN = 1 + ROUNDS * (SETTLE + 2) + 1;

  typedef struct {
    int err_a;
    int err_b;
    int pass;
  } exp_t;

  logic clk;
  logic rst_n;
  logic start;
  int   mode;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  dnot_checker_if #(.ERR_W(8)) bus_a ();
  dnot_checker_if #(.ERR_W(4)) bus_b ();

  dnot_checker #(.ROUNDS(ROUNDS), .SETTLE(SETTLE), .ERR_W(8)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  dnot_checker #(.ROUNDS(ROUNDS), .SETTLE(SETTLE), .ERR_W(4)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  assign bus_a.start = start;
  assign bus_b.start = start;

  // Example under test: 0 = correct inverters, 1 = NOT/OR output stuck low, 2 = buffers.
  always_comb begin
    case (mode)
      1: begin
        bus_a.obs_not  = ~bus_a.stim;
        bus_a.obs_dnot = 1'b0;
        bus_b.obs_not  = ~bus_b.stim;
        bus_b.obs_dnot = 1'b0;
      end
      2: begin
        bus_a.obs_not  = bus_a.stim;
        bus_a.obs_dnot = bus_a.stim;
        bus_b.obs_not  = bus_b.stim;
        bus_b.obs_dnot = bus_b.stim;
      end
      default: begin
        bus_a.obs_not  = ~bus_a.stim;
        bus_a.obs_dnot = ~bus_a.stim | 1'b0;
        bus_b.obs_not  = ~bus_b.stim;
        bus_b.obs_dnot = ~bus_b.stim | 1'b0;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_err(input int m, input int nrounds, input int maxv);
    int e;
    int s;
    int expv;
    int o_not;
    int o_dnot;
    e = 0;
    for (int r = 0; r < nrounds; r++) begin
      s    = r % 2;
      expv = 1 - s;
      case (m)
        1:       begin o_not = expv; o_dnot = 0; end
        2:       begin o_not = s;    o_dnot = s; end
        default: begin o_not = expv; o_dnot = expv; end
      endcase
      e = e + ((o_not != expv) ? 1 : 0) + ((o_dnot != expv) ? 1 : 0);
      if (e > maxv) e = maxv;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Start nruns runs (start held for back-to-back), optionally hammering start while busy.
  task automatic run(input string tag, input int m, input bit hammer, input int nruns);
    int   done_k[$];
    exp_t e;
    int   p;
    int   j;
    int   lim;
    mode = m;
    for (int i = 0; i < nruns; i++) begin
      e.err_a = model_err(m, ROUNDS, 255);
      e.err_b = model_err(m, ROUNDS, 15);
      e.pass  = (e.err_a == 0) ? 1 : 0;
      sb.push_back(e);
    end
    lim = RUN_LEN * nruns + 4;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (hammer) start = (k < 60) ? ((k % 2) == 1) : 1'b0;
      else        start = (k <= RUN_LEN * (nruns - 1));
      j = (k - 1) / RUN_LEN;
      p = (k - 1) % RUN_LEN + 1;
      if (j < nruns) begin
        if (p == 1) chk({tag, " busy_at_drive"}, int'(bus_a.busy), 1);
        if (p <= RUN_LEN - 2 && (p - 1) % (SETTLE + 2) == 1)
          chk({tag, " stim"}, int'(bus_a.stim), ((p - 1) / (SETTLE + 2)) % 2);
        if (p == RUN_LEN) begin
          chk({tag, " busy_after_done"}, int'(bus_a.busy), 0);
          chk({tag, " stim_after_done"}, int'(bus_a.stim), 0);
        end
      end
      if (bus_a.done === 1'b1) begin
        done_k.push_back(k);
        chk({tag, " sb_pending"}, int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, " err_cnt_a"}, int'(bus_a.err_cnt), e.err_a);
          chk({tag, " err_cnt_b"}, int'(bus_b.err_cnt), e.err_b);
          chk({tag, " pass_a"}, int'(bus_a.pass), e.pass);
          chk({tag, " pass_b"}, int'(bus_b.pass), e.pass);
          chk({tag, " done_b"}, int'(bus_b.done), 1);
        end
      end
    end
    chk({tag, " done_count"}, done_k.size(), nruns);
    foreach (done_k[i]) chk({tag, " done_cycle"}, done_k[i], RUN_LEN - 1 + RUN_LEN * i);
    chk({tag, " sb_empty"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    mode     = 0;
    start    = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset stim", int'(bus_a.stim), 0);
    chk("reset busy", int'(bus_a.busy), 0);
    chk("reset done", int'(bus_a.done), 0);
    chk("reset pass", int'(bus_a.pass), 0);
    chk("reset err_cnt_a", int'(bus_a.err_cnt), 0);
    chk("reset err_cnt_b", int'(bus_b.err_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("correct", 0, 1'b0, 1);
    run("dnot_stuck0", 1, 1'b0, 1);
    run("noninv", 2, 1'b0, 1);

    // Abort a run with reset in round 5.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 2 + 5 * (SETTLE + 2); k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort pre err_cnt_a", int'(bus_a.err_cnt), model_err(2, 5, 255));
    chk("abort pre err_cnt_b", int'(bus_b.err_cnt), model_err(2, 5, 15));
    chk("abort pre stim", int'(bus_a.stim), 1);
    chk("abort pre busy", int'(bus_a.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort stim", int'(bus_a.stim), 0);
    chk("abort busy", int'(bus_a.busy), 0);
    chk("abort pass", int'(bus_a.pass), 0);
    chk("abort err_cnt_a", int'(bus_a.err_cnt), 0);
    chk("abort err_cnt_b", int'(bus_b.err_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("after_reset", 0, 1'b0, 1);
    run("hammer", 0, 1'b1, 1);
    run("held", 1, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
